// File: rtl/m65c02_add_seq_pkg.sv
// Shared definitions for the multi-byte ADC/SBC sequencer.
//   state_t      : sequencer FSM encoding
//   OP_ADD/OP_SUB: values of the Op request bit
//   NBYTES_MIN/MAX: legal range of the operand width parameter
package m65c02_add_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int NBYTES_MIN = 1;
    localparam int NBYTES_MAX = 4;

endpackage

// File: rtl/m65c02_add_seq.sv
// Multi-byte sequencer for the shared 8-bit binary/decimal adder.
// Accepts one ADC/SBC request of 1 or NBYTES bytes and walks the adder one
// byte per cycle, low byte first, chaining the carry. Collects Sum and N/V/Z/C.
// Ports:
//   Clk, Rst_N              : clock, async active-low reset
//   Req, Op, D, W, A, B, Ci : request (sampled in IDLE only) and operands
//   Busy, Done              : not-idle status, one-cycle result strobe
//   Sum, Co, OV, N, Z, Err  : result, flags, sticky adder-invalid error
//   En_AU, En_DU, AddOp, AddQ, AddR, AddCi : adder drive (zero outside RUN)
//   AddOut, AddOV, AddVal   : adder result {carry,sum}, overflow, valid
module m65c02_add_seq
    import m65c02_add_seq_pkg::*;
#(
    parameter int NBYTES = 2
) (
    input  logic                  Clk,
    input  logic                  Rst_N,
    input  logic                  Req,
    input  logic                  Op,
    input  logic                  D,
    input  logic                  W,
    input  logic [8*NBYTES-1:0]   A,
    input  logic [8*NBYTES-1:0]   B,
    input  logic                  Ci,
    output logic                  Busy,
    output logic                  Done,
    output logic [8*NBYTES-1:0]   Sum,
    output logic                  Co,
    output logic                  OV,
    output logic                  N,
    output logic                  Z,
    output logic                  Err,
    output logic                  En_AU,
    output logic                  En_DU,
    output logic                  AddOp,
    output logic [7:0]            AddQ,
    output logic [7:0]            AddR,
    output logic                  AddCi,
    input  logic [8:0]            AddOut,
    input  logic                  AddOV,
    input  logic                  AddVal
);

    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    if (NBYTES < NBYTES_MIN || NBYTES > NBYTES_MAX) begin : g_bad_nbytes
        $error("m65c02_add_seq: NBYTES out of range");
    end

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    idx;
    logic [8*NBYTES-1:0] a_r, b_r, sum_nxt;
    logic                op_r, d_r, w_r, ci_r, carry_r;
    logic                run, last;

    assign run  = (state == ST_RUN);
    // W=0 finishes on the first byte; W=1 on the top byte.
    assign last = ~w_r | (idx == LAST_IDX);

    // FSM state register
    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (Req) state_nxt = ST_RUN;
            ST_RUN:  if (last) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Sum with the current adder byte merged in; Z is taken from this so the
    // last byte is included in the same edge that captures it.
    always_comb begin
        sum_nxt = Sum;
        sum_nxt[{idx, 3'b000} +: 8] = AddOut[7:0];
    end

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            a_r     <= '0;
            b_r     <= '0;
            op_r    <= 1'b0;
            d_r     <= 1'b0;
            w_r     <= 1'b0;
            ci_r    <= 1'b0;
            carry_r <= 1'b0;
            idx     <= '0;
            Sum     <= '0;
            Co      <= 1'b0;
            OV      <= 1'b0;
            N       <= 1'b0;
            Z       <= 1'b0;
            Err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (Req) begin
                    a_r  <= A;
                    b_r  <= B;
                    op_r <= Op;
                    d_r  <= D;
                    w_r  <= W;
                    ci_r <= Ci;
                    idx  <= '0;
                    Sum  <= '0;   // upper bytes stay 0 for an 8-bit op
                end
                ST_RUN: begin
                    Sum     <= sum_nxt;
                    carry_r <= AddOut[8];
                    if (!AddVal) Err <= 1'b1;
                    if (last) begin
                        Co <= AddOut[8];
                        OV <= AddOV;
                        N  <= AddOut[7];
                        Z  <= ~|sum_nxt;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy  = (state != ST_IDLE);
    assign Done  = (state == ST_DONE);

    // Adder drive is gated by RUN so an async reset drops the enables at once.
    assign En_AU = run & ~d_r;
    assign En_DU = run &  d_r;
    assign AddOp = run &  op_r;
    assign AddQ  = run ? a_r[{idx, 3'b000} +: 8] : 8'h00;
    assign AddR  = run ? b_r[{idx, 3'b000} +: 8] : 8'h00;
    assign AddCi = run & ((idx == '0) ? ci_r : carry_r);

endmodule

// File: doc/m65c02_add_seq.md
Name: m65c02_add_seq

Overview:
Multi-byte sequencer for the shared 8-bit binary/decimal adder unit. It accepts one 8- or 16-bit ADC/SBC request and drives the adder one byte per cycle, low byte first, chaining the carry between bytes. It collects the result and the N/V/Z/C flags. It sits between the ALU control and the adder, and it is the only block that drives the adder's enable, operation and operand inputs.

Parameters:
NBYTES, 2, maximum operand width in bytes; legal values 1..4. The W input selects 1 byte or NBYTES bytes.

Ports:
Clk  in  1  system clock; the adder's decimal stage uses the falling edge.
Rst_N  in  1  asynchronous reset, active-low.
Req  in  1  operation request; sampled only in IDLE.
Op  in  1  0 = add (ADC), 1 = subtract (SBC).
D  in  1  1 = decimal (BCD) mode, 0 = binary.
W  in  1  0 = 8-bit operation, 1 = NBYTES-byte operation.
A  in  8*NBYTES  left operand.
B  in  8*NBYTES  right operand; uncomplemented, the adder complements it.
Ci  in  1  carry in to the low byte.
Busy  out  1  high in any state other than IDLE.
Done  out  1  one-cycle pulse when the result is valid.
Sum  out  8*NBYTES  result; upper bytes are 0 for W=0.
Co, OV, N, Z  out  1 each  result flags.
Err  out  1  sticky flag: adder returned Val low during an active byte cycle.
En_AU  out  1  adder binary enable.
En_DU  out  1  adder decimal enable.
AddOp  out  1  adder operation select.
AddQ  out  8  adder left operand.
AddR  out  8  adder right operand.
AddCi  out  1  adder carry in.
AddOut  in  9  adder result, {carry, sum}.
AddOV  in  1  adder overflow.
AddVal  in  1  adder result valid.

Behaviour:
- Reset (Rst_N low, asynchronous):
  - state = IDLE.
  - All outputs 0, including Sum, flags, Err, En_AU and En_DU.
  - Operand capture registers and the byte index are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On a rising edge with Req=1, capture A, B, Op, D, W and Ci.
  - Clear the byte index to 0 and go to RUN.
  - Req=0: stay in IDLE.
- RUN (one cycle per byte, index i):
  - En_AU = ~D_r and En_DU = D_r. The two are never both high and never both low in RUN; both are 0 outside RUN.
  - AddOp = Op_r.
  - AddQ = A_r byte i, AddR = B_r byte i.
  - AddCi = Ci_r for i=0, otherwise the carry stored from byte i-1.
  - The decimal result settles in the second half of the cycle.
  - At the rising edge ending each RUN cycle:
    - Store AddOut[7:0] into Sum byte i, and store AddOut[8] as the chain carry.
    - If AddVal=0, set Err; the sequence still completes.
  - Last byte is i=0 for W=0 and i=NBYTES-1 for W=1. After the last byte go to DONE; otherwise increment i and stay in RUN.
- DONE:
  - Done=1 for exactly one cycle, then go to IDLE.
  - Co = carry of the last byte; OV = AddOV of the last byte, captured with it.
  - N = bit 7 of the last byte.
  - Z = 1 iff all produced bytes are 0. Flags reflect the BCD-adjusted result in decimal mode.
  - In decimal SBC, Co=1 means no borrow.
- Holding and ignored inputs:
  - Sum and the flags hold until the next accepted request, which clears Sum at acceptance.
  - Err clears only on reset.
  - Req is ignored while Busy=1. No queueing; the requester must re-assert.
- Latency: an 8-bit operation has Done 2 cycles after the accept edge; a 16-bit operation has Done 3 cycles after it. Throughput is one accept per (bytes+2) cycles, since IDLE is mandatory between operations.
- Reset mid-operation aborts immediately and discards the partial result. En_AU and En_DU drop asynchronously, which also resets the adder's internal stage.
- Input changes on A, B, Op, D, W and Ci after acceptance have no effect.

Decomposition:
- Shared package holds:
  - State encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10).
  - Op constants (OP_ADD=0, OP_SUB=1).
  - The NBYTES legal range.
- No sub-module. The adder unit is instantiated beside this block at the ALU level.
- Byte selection is an indexed part-select; the zero detect is an OR-reduce.

Test Plan:
1. 8-bit binary: W=0, D=0, Op=0, A=0x7F, B=0x01, Ci=0 -> Done 2 cycles after accept; Sum=0x0080, Co=0, OV=1, N=1, Z=0.
2. 16-bit binary: A=0xFFFF, B=0x0001, Ci=0 -> byte 1 sees AddCi=1; Sum=0x0000, Co=1, Z=1, N=0; Done 3 cycles after accept.
3. 16-bit decimal add: D=1, A=0x0999, B=0x0001, Ci=0 -> En_DU=1 and En_AU=0 in both RUN cycles; Sum=0x1000, Co=0, Z=0.
4. 16-bit decimal subtract: D=1, Op=1, A=0x1000, B=0x0001, Ci=1 -> byte 0=0x99 with carry 0; Sum=0x0999, Co=1.
5. Req held high across a whole operation -> exactly one accept; the second accept occurs on the first edge in IDLE after DONE; operand changes while Busy=1 do not affect Sum.
6. Rst_N pulsed low during RUN of a 16-bit operation -> all outputs 0 immediately; after release Busy=0 and Err=0; a following 8-bit 0x05+0x03 gives Sum=0x0008.
